sdu_uart_rx: RTL and testbench
==============================

Name: sdu_uart_rx

Overview:
- UART receive front end that feeds the serial debug unit's command parser.
- Takes the raw asynchronous rxd pin, oversamples it at 16x baud and deframes 8N1 characters.
- Completed bytes are buffered in a small FIFO and presented on a valid/ready byte stream.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 4, receive buffer depth in bytes; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input; idle high.
- dout  out  8  byte at FIFO head.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset values: dout=0, dout_valid=0, frame_err=0, overrun=0, busy=0. The synchronizer resets to 1, the FIFO empties, and the FSM goes to IDLE.
- Reset mid-frame aborts the frame; any partial byte is discarded.
- Input path: 2-FF synchronizer on rxd, so 2 cycles of latency before the FSM sees an edge.
- Tick generator: DIV = CLK_FREQ/(BAUD*16), integer floor (54 at the defaults). The counter counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - The counter is free-running in IDLE.
  - It is restarted at 0 when a falling edge is detected.
- Per-bit sample counter, 0..15. Bit value = majority of the synchronized samples taken at ticks 7, 8 and 9.
- FSM states and transitions:
  - IDLE: a synchronized falling edge goes to START.
  - START: majority at bit end. A 1 is a glitch and returns to IDLE with no output. A 0 goes to DATA.
  - DATA: 8 bits shifted in LSB first into a shift register; after bit 7 go to PARITY (when the feature is compiled in) or STOP.
  - STOP:
    - Majority 1 → push the byte into the FIFO and go to IDLE. The push occurs at tick 9 of the stop bit, so the line is re-armed half a bit early.
    - Majority 0 → pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stays until the synchronized rxd has been high for 16 consecutive ticks, then goes to IDLE. This handles break conditions.
- FIFO:
  - Push and pop in the same cycle when full: the pop happens first and the push succeeds, with no overrun.
  - Push when full without a pop: byte dropped, overrun pulses for 1 cycle, FIFO contents unchanged.
  - Empty with a pending push: dout_valid rises the cycle after the push. There is no fall-through.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty are distinguished by the MSB.
- dout is registered from FIFO head and is stable while dout_valid && !dout_ready.
- Total latency from the stop-bit mid-sample to dout_valid is ≤ 4 clk.

Optional Feature:
- Macro: SDU_RX_PARITY_EN.
- Defined:
  - The frame is 8E1. A PARITY state sits between DATA and STOP and samples the 9th bit.
  - The expected value is the XOR of the 8 data bits.
  - On mismatch the byte is discarded at STOP and frame_err pulses. A mismatch combined with a bad stop still gives a single pulse.
- Undefined: 8N1, the PARITY state does not exist, and the frame is 10 bits.

Decomposition:
- Shared package sdu_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - the OVERSAMPLE=16 constant;
  - the MAJ_T0/T1/T2 = 7/8/9 sample indices;
  - a function computing DIV from CLK_FREQ and BAUD.
- One natural sub-module: sdu_byte_fifo, a synchronous FIFO with params WIDTH=8 and DEPTH, and ports push, din, pop, dout, full, empty.

Test Plan:
- Reset and idle: hold rst for 5 cycles with rxd=1 → all outputs 0, busy=0. Assert rst mid-frame → no byte, FSM returns to IDLE.
- Single byte: send 0xA5 8N1 at 864 clk/bit with dout_ready=1 → dout=0xA5 with dout_valid high 1 cycle, frame_err=0, overrun=0.
- Glitch rejection: rxd low for 300 clk then high → FSM returns to IDLE, no dout_valid, no frame_err.
- Framing error: send 0x3C with the stop bit held 0, rxd then kept low 2000 clk before returning high → one frame_err pulse, no byte, then 0x5A received correctly.
- Overrun: with dout_ready=0, send 0x01..0x05 → overrun pulses once on the 5th byte. With ready=1 the bench then pops 0x01,0x02,0x03,0x04 in order. A simultaneous pop and push when full gives no overrun.
- Parity (SDU_RX_PARITY_EN): 0x07 with parity bit 1 → accepted. 0x07 with parity bit 0 → frame_err pulse, no byte.

Source files
------------

// File: rtl/sdu_pkg.sv
// Shared types and constants for the serial debug unit UART receiver.
package sdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MAJ_T0     = 7;
  localparam int MAJ_T1     = 8;
  localparam int MAJ_T2     = 9;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sdu_byte_fifo.sv
// Small synchronous byte FIFO; registered storage, no fall-through.
// A pop on a full FIFO frees the slot that a same-cycle push then takes.
module sdu_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdu_uart_rx.sv
// 16x oversampling UART receiver (8N1; 8E1 when SDU_RX_PARITY_EN is defined)
// feeding a byte FIFO with a valid/ready output stream.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | qualifying the start bit (glitch filter)
// DATA      | shifting in 8 data bits, LSB first
// PARITY    | sampling the even-parity bit (parity build only)
// STOP      | sampling the stop bit, pushing the byte
// WAIT_IDLE | after a framing error, waiting for 16 high ticks
module sdu_uart_rx
  import sdu_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int            DIV      = calc_div(CLK_FREQ, BAUD);
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t        state;
  logic          rxd_s1, rxd_s2, rxd_q;
  logic [DW-1:0] div_cnt;
  logic [3:0]    samp_cnt, hi_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          s_t0, s_t1, bit_val, push;
  logic          tick, fall, maj, mid_bit, end_bit, good_stop;
  logic          fifo_full, fifo_empty, pop;
`ifdef SDU_RX_PARITY_EN
  logic          par_err;
  assign good_stop = maj & ~par_err;
`else
  assign good_stop = maj;
`endif

  assign tick       = (div_cnt == DIV_LAST);
  assign fall       = rxd_q & ~rxd_s2;
  assign maj        = (s_t0 & s_t1) | (s_t0 & rxd_s2) | (s_t1 & rxd_s2);
  assign mid_bit    = tick && (samp_cnt == 4'(MAJ_T2));
  assign end_bit    = tick && (samp_cnt == 4'(OVERSAMPLE - 1));
  assign dout_valid = ~fifo_empty;
  assign pop        = dout_valid & dout_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) {rxd_s1, rxd_s2, rxd_q} <= 3'b111;
    else     {rxd_s1, rxd_s2, rxd_q} <= {rxd, rxd_s1, rxd_s2};
  end

  always_ff @(posedge clk) begin
    if (rst)                        div_cnt <= '0;
    else if (state == IDLE && fall) div_cnt <= '0;
    else if (tick)                  div_cnt <= '0;
    else                            div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      hi_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      s_t0      <= 1'b1;
      s_t1      <= 1'b1;
      bit_val   <= 1'b1;
      push      <= 1'b0;
      frame_err <= 1'b0;
`ifdef SDU_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      if (tick) begin
        samp_cnt <= samp_cnt + 4'd1;
        if (samp_cnt == 4'(MAJ_T0)) s_t0 <= rxd_s2;
        if (samp_cnt == 4'(MAJ_T1)) s_t1 <= rxd_s2;
      end
      if (mid_bit) bit_val <= maj;
      unique case (state)
        IDLE: if (fall) begin
          state    <= START;
          samp_cnt <= '0;
        end
        START: if (end_bit) begin
          if (bit_val) state <= IDLE;
          else begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (mid_bit) shreg <= {maj, shreg[7:1]};
          if (end_bit) begin
            if (bit_idx == 3'd7) begin
`ifdef SDU_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else bit_idx <= bit_idx + 3'd1;
          end
        end
`ifdef SDU_RX_PARITY_EN
        PARITY: begin
          if (mid_bit) par_err <= maj ^ (^shreg);
          if (end_bit) state <= STOP;
        end
`endif
        // Decide at mid-stop so the next start edge is caught early.
        STOP: if (mid_bit) begin
          if (good_stop) begin
            push  <= 1'b1;
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            hi_cnt    <= '0;
            state     <= maj ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: if (tick) begin
          if (!rxd_s2)              hi_cnt <= '0;
          else if (hi_cnt == 4'd15) state  <= IDLE;
          else                      hi_cnt <= hi_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= push & fifo_full & ~pop;
  end

  sdu_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sdu_uart_rx.sv
// Randomized bench for sdu_uart_rx against a queue-based byte/error model.
module tb_sdu_uart_rx;

  localparam int CLK_FREQ = 12_800_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int BIT      = CLK_FREQ / BAUD;
`ifdef SDU_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, dout_ready = 1'b1;
  logic [7:0] dout;
  logic       dout_valid, frame_err, overrun, busy;

  always #5 clk = ~clk;

  sdu_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  int         n_cmp = 0, n_bad = 0;
  int         fe_cycles = 0, ov_cycles = 0, valid_cycles = 0;
  int         exp_fe = 0, exp_ov = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Samples 1 ns before each rising edge; inputs only change 1 ns after an edge.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (frame_err)  fe_cycles++;
        if (overrun)    ov_cycles++;
        if (dout_valid) valid_cycles++;
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h, expected none", dout);
          end else begin
            e = exp_q.pop_front();
            chk("byte", dout, e);
          end
          last_byte = dout;
        end
      end
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic model_push(input logic [7:0] d);
    if (exp_q.size() >= DEPTH) exp_ov++;
    else exp_q.push_back(d);
  endtask

  // The model updates a little before mid-stop, ahead of the receiver's push.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit flip_par,
                            input bit model, input int bit_len);
    bit ok;
    ok = stop_bit && !(flip_par && PARITY_ON);
    drive_bit(1'b0, bit_len);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_len);
    if (PARITY_ON) drive_bit((^d) ^ flip_par, bit_len);
    rxd = stop_bit;
    repeat (BIT * 3 / 8) @(posedge clk);
    #1;
    if (model) begin
      if (ok) model_push(d);
      else exp_fe++;
    end
    repeat (bit_len - BIT * 3 / 8) @(posedge clk);
    #1;
  endtask

  // Raise ready for exactly the cycle in which the stop-bit push lands on a full FIFO.
  task automatic coincide();
    int n;
    n = 0;
    while (!busy && n < 2000) begin @(negedge clk); n++; end
    while (busy && n < 20000) begin @(negedge clk); n++; end
    chk("coincide_timeout", (n >= 20000) ? 1 : 0, 0);
    #1 dout_ready = 1'b1;
    @(posedge clk);
    #1 dout_ready = 1'b0;
    model_push(8'h15);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [7:0] d;
    fork monitor(); join_none

    rst = 1'b1; rxd = 1'b1; dout_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(50);

    v0 = valid_cycles;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, BIT);
    idle(100);
    chk("single_valid_cycles", valid_cycles - v0, 1);
    chk("single_byte", last_byte, 8'hA5);
    chk("single_queue", exp_q.size(), 0);
    chk("single_fe", fe_cycles, 0);
    chk("single_ov", ov_cycles, 0);

    v0 = valid_cycles;
    drive_bit(1'b0, 40);
    idle(3 * BIT);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", valid_cycles - v0, 0);
    chk("glitch_fe", fe_cycles, 0);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, BIT);
    drive_bit(1'b0, 300);
    idle(3 * BIT);
    chk("frame_err_pulse", fe_cycles, 1);
    chk("frame_err_model", fe_cycles, exp_fe);
    chk("frame_err_busy", busy, 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, BIT);
    idle(100);
    chk("after_break_byte", last_byte, 8'h5A);
    chk("after_break_queue", exp_q.size(), 0);

    v0 = valid_cycles;
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT / 2);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_busy", busy, 0);
    idle(12 * BIT);
    chk("midrst_valid", valid_cycles - v0, 0);
    chk("midrst_busy_later", busy, 0);
    chk("midrst_fe", fe_cycles, exp_fe);

    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b1, BIT);
    idle(20);
    chk("overrun_pulse", ov_cycles, 1);
    chk("overrun_model", ov_cycles, exp_ov);
    chk("overrun_hold_valid", dout_valid, 1);
    chk("overrun_head", dout, 8'h01);
    dout_ready = 1'b1;
    idle(20);
    chk("overrun_drain_queue", exp_q.size(), 0);
    chk("overrun_last", last_byte, 8'h04);

    dout_ready = 1'b0;
    for (int i = 8'h11; i <= 8'h14; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b1, BIT);
    idle(20);
    fork
      send_frame(8'h15, 1'b1, 1'b0, 1'b0, BIT);
      coincide();
    join
    idle(20);
    chk("coincide_no_overrun", ov_cycles, 1);
    chk("coincide_model_ov", ov_cycles, exp_ov);
    dout_ready = 1'b1;
    idle(20);
    chk("coincide_last", last_byte, 8'h15);
    chk("coincide_queue", exp_q.size(), 0);

    for (int k = 0; k < 12; k++) begin
      dout_ready = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      send_frame(d, 1'b1, 1'b0, 1'b1, BIT - 1 + int'($urandom_range(0, 2)));
      idle(int'($urandom_range(5, 200)));
    end
    dout_ready = 1'b1;
    idle(50);
    chk("random_queue", exp_q.size(), 0);
    chk("random_ov", ov_cycles, exp_ov);
    chk("random_fe", fe_cycles, exp_fe);

    if (PARITY_ON) begin
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, BIT);
      idle(100);
      chk("parity_ok_byte", last_byte, 8'h07);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, BIT);
      idle(100);
      chk("parity_bad_fe", fe_cycles, exp_fe);
      chk("parity_bad_queue", exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
